// File: rtl/flow_led.sv
// rtl/flow_led.sv - flowing-light LED driver; macro FLOW_LED_SIM_FAST_EN reads FLOW_PERIOD as cycles
module flow_led #(
  parameter int         LED_NUM     = 8,
  parameter logic       LED_ON_MODE = 1'b1,
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         FLOW_PERIOD = 1,
  parameter logic [1:0] FLOW_MODE   = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  output logic [LED_NUM-1:0] led_o
);

`ifdef FLOW_LED_SIM_FAST_EN
  localparam int STEP_CYC = FLOW_PERIOD;
`else
  localparam int STEP_CYC = (CLK_FREQ / 1000) * FLOW_PERIOD;
`endif

  localparam int                 CNT_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYC - 1);
  // Right rotation starts at the top LED; every other mode starts at bit0.
  localparam logic [LED_NUM-1:0] PAT_INIT = (FLOW_MODE == 2'd1) ?
                                            (LED_NUM'(1) << (LED_NUM - 1)) : LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_OFF  = {LED_NUM{~LED_ON_MODE}};

  // run_q distinguishes the load edge from later edges, since bar-fill
  // legitimately passes through an all-zero pattern while running.
  logic               run_q, run_d;
  logic               dir_right_q, dir_right_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_NUM-1:0] pat_q, pat_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [LED_NUM-1:0] adv_pat;
  logic               adv_dir_right;

  // State register: async reset to dark, direction left, counter cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      dir_right_q <= 1'b0;
      cnt_q       <= '0;
      pat_q       <= '0;
      led_q       <= LED_OFF;
    end else begin
      run_q       <= run_d;
      dir_right_q <= dir_right_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      led_q       <= led_d;
    end
  end

  // Pattern and direction one step ahead of the current pattern.
  always_comb begin
    adv_pat       = pat_q;
    adv_dir_right = dir_right_q;
    case (FLOW_MODE)
      2'd0: begin
        for (int i = 0; i < LED_NUM; i++) adv_pat[(i + 1) % LED_NUM] = pat_q[i];
      end
      2'd1: begin
        for (int i = 0; i < LED_NUM; i++) adv_pat[i] = pat_q[(i + 1) % LED_NUM];
      end
      2'd2: begin
        // A single LED has nowhere to bounce, so it simply stays lit.
        if (LED_NUM > 1) begin
          adv_pat = '0;
          if (!dir_right_q) begin
            for (int i = 0; i < LED_NUM - 1; i++) adv_pat[i + 1] = pat_q[i];
            if (adv_pat[LED_NUM-1]) adv_dir_right = 1'b1;
          end else begin
            for (int i = 0; i < LED_NUM - 1; i++) adv_pat[i] = pat_q[i + 1];
            if (adv_pat[0]) adv_dir_right = 1'b0;
          end
        end
      end
      default: begin
        // Fill from bit0 until full, then one dark step, then start again.
        if (&pat_q) begin
          adv_pat = '0;
        end else begin
          adv_pat[0] = 1'b1;
          for (int i = 0; i < LED_NUM - 1; i++) adv_pat[i + 1] = pat_q[i];
        end
      end
    endcase
  end

  // Next state: clear while disabled, load on first enabled edge, advance on counter wrap.
  always_comb begin
    run_d       = run_q;
    dir_right_d = dir_right_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    if (!en_i) begin
      run_d       = 1'b0;
      dir_right_d = 1'b0;
      cnt_d       = '0;
      pat_d       = '0;
    end else if (!run_q) begin
      run_d       = 1'b1;
      dir_right_d = 1'b0;
      cnt_d       = '0;
      pat_d       = PAT_INIT;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      pat_d       = adv_pat;
      dir_right_d = adv_dir_right;
    end else begin
      cnt_d       = cnt_q + CNT_W'(1);
    end
  end

  // Output: drive polarity applied to the next pattern so led_o is a plain register.
  always_comb begin
    led_d = LED_ON_MODE ? pat_d : ~pat_d;
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_flow_led.sv
// tb/tb_flow_led.sv - directed self-checking bench for flow_led
module tb_flow_led;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_rl, en_rr, en_pp, en_bar, en_tg, en_hd;
  logic [4:0] led_rl, led_rr, led_pp;
  logic [3:0] led_bar;
  logic [0:0] led_tg, led_hd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // CLK_FREQ=1000 with FLOW_PERIOD=4 gives a 4-cycle step with or without the fast-sim macro.
  flow_led #(.LED_NUM(5), .LED_ON_MODE(1'b1), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd0))
    u_rl (.clk(clk), .rst_n(rst_n), .en_i(en_rl), .led_o(led_rl));
  flow_led #(.LED_NUM(5), .LED_ON_MODE(1'b1), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd1))
    u_rr (.clk(clk), .rst_n(rst_n), .en_i(en_rr), .led_o(led_rr));
  flow_led #(.LED_NUM(5), .LED_ON_MODE(1'b0), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd2))
    u_pp (.clk(clk), .rst_n(rst_n), .en_i(en_pp), .led_o(led_pp));
  flow_led #(.LED_NUM(4), .LED_ON_MODE(1'b1), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd3))
    u_bar (.clk(clk), .rst_n(rst_n), .en_i(en_bar), .led_o(led_bar));
  flow_led #(.LED_NUM(1), .LED_ON_MODE(1'b1), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd3))
    u_tg (.clk(clk), .rst_n(rst_n), .en_i(en_tg), .led_o(led_tg));
  flow_led #(.LED_NUM(1), .LED_ON_MODE(1'b1), .CLK_FREQ(1000), .FLOW_PERIOD(4), .FLOW_MODE(2'd0))
    u_hd (.clk(clk), .rst_n(rst_n), .en_i(en_hd), .led_o(led_hd));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [4:0] rl_seq [4] = '{5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [4:0] pp_seq [10] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111,
                              5'b10111, 5'b11011, 5'b11101, 5'b11110, 5'b11101};
  logic [3:0] bar_seq [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001, 4'b0011};

  initial begin
    rst_n = 1'b0;
    en_rl = 1'b0; en_rr = 1'b0; en_pp = 1'b0; en_bar = 1'b0; en_tg = 1'b0; en_hd = 1'b0;

    // Reset and idle
    step(3);
    check("reset_pp_all_off", 32'(led_pp), 32'(5'b11111));
    check("reset_rl_zero", 32'(led_rl), 32'(5'b00000));
    rst_n = 1'b1;
    step(3);
    check("idle_pp_all_off", 32'(led_pp), 32'(5'b11111));
    check("idle_bar_zero", 32'(led_bar), 32'(4'b0000));

    // Rotate left
    en_rl = 1'b1;
    step(1);
    check("rl_load", 32'(led_rl), 32'(5'b00001));
    step(3);
    check("rl_hold_before_step", 32'(led_rl), 32'(5'b00001));
    step(1);
    check("rl_first_step", 32'(led_rl), 32'(5'b00010));
    for (int i = 0; i < 4; i++) begin
      step(4);
      check($sformatf("rl_step%0d", i), 32'(led_rl), 32'(rl_seq[i]));
    end
    step(12);
    check("rl_at_01000", 32'(led_rl), 32'(5'b01000));

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rl", 32'(led_rl), 32'(5'b00000));
    check("async_rst_pp", 32'(led_pp), 32'(5'b11111));
    en_rl = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst_rl_idle", 32'(led_rl), 32'(5'b00000));

    // Ping-pong, active-low
    en_pp = 1'b1;
    step(1);
    check("pp_step0", 32'(led_pp), 32'(pp_seq[0]));
    for (int i = 1; i < 10; i++) begin
      step(4);
      check($sformatf("pp_step%0d", i), 32'(led_pp), 32'(pp_seq[i]));
    end
    en_pp = 1'b0;
    step(1);
    check("pp_disable", 32'(led_pp), 32'(5'b11111));

    // Bar fill
    en_bar = 1'b1;
    step(1);
    check("bar_step0", 32'(led_bar), 32'(bar_seq[0]));
    for (int i = 1; i < 7; i++) begin
      step(4);
      check($sformatf("bar_step%0d", i), 32'(led_bar), 32'(bar_seq[i]));
    end
    en_bar = 1'b0;

    // Rotate right with disable and re-enable
    en_rr = 1'b1;
    step(1);
    check("rr_load", 32'(led_rr), 32'(5'b10000));
    step(4);
    check("rr_step1", 32'(led_rr), 32'(5'b01000));
    step(4);
    check("rr_step2", 32'(led_rr), 32'(5'b00100));
    step(1);
    en_rr = 1'b0;
    step(1);
    check("rr_disable", 32'(led_rr), 32'(5'b00000));
    en_rr = 1'b1;
    step(1);
    check("rr_reload", 32'(led_rr), 32'(5'b10000));
    step(3);
    check("rr_reload_hold", 32'(led_rr), 32'(5'b10000));
    step(1);
    check("rr_reload_step", 32'(led_rr), 32'(5'b01000));
    en_rr = 1'b0;

    // Single-LED corner cases
    en_tg = 1'b1;
    en_hd = 1'b1;
    step(1);
    check("one_bar_on", 32'(led_tg), 32'(1'b1));
    check("one_rot_on", 32'(led_hd), 32'(1'b1));
    step(4);
    check("one_bar_off", 32'(led_tg), 32'(1'b0));
    check("one_rot_hold1", 32'(led_hd), 32'(1'b1));
    step(4);
    check("one_bar_on_again", 32'(led_tg), 32'(1'b1));
    check("one_rot_hold2", 32'(led_hd), 32'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
